bkm_step: RTL and testbench

BKM_STEP -- requirements
Module: bkm_step

---
 rtl/bkm_step.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_bkm_step.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bkm_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bkm_step                                                     |
// | Description : One registered step of a BKM rotation/logarithm iteration.   |
// |               E-mode rotates (X,Y) by the shifted-digit term and steps     |
// |               (u,v) down by table constants; L-mode does the reverse.      |
// |               X/Y travel in CSD (two bits per digit), u/v in two's         |
// |               complement. Datapath is W+2 bits wide, then reduced to W     |
// |               bits by wrap or, when BKM_STEP_SAT_EN is defined, optional   |
// |               saturation selected by format[0].                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bkm_step #(
  parameter int W     = 8,
  parameter int LOG2W = 3,
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             srst,
  input  logic             enable,
  input  logic             mode,
  input  logic [1:0]       format,
  input  logic [LOG2N-1:0] n,
  input  logic [1:0]       d_x_n,
  input  logic [1:0]       d_y_n,
  input  logic [2*W-1:0]   X_n,
  input  logic [2*W-1:0]   Y_n,
  input  logic [2*W-1:0]   lut_X,
  input  logic [2*W-1:0]   lut_Y,
  input  logic [W-1:0]     u_n,
  input  logic [W-1:0]     v_n,
  input  logic [W-1:0]     lut_u,
  input  logic [W-1:0]     lut_v,
  output logic [2*W-1:0]   X_np1,
  output logic [2*W-1:0]   Y_np1,
  output logic [W-1:0]     u_np1,
  output logic [W-1:0]     v_np1
);

  // Internal word: two guard bits above W hold the worst-case sum of three terms.
  localparam int WE = W + 2;
  // Shift amount needs one extra bit so it can express a full-width shift (= sign fill).
  localparam int SW = LOG2W + 1;

  localparam logic signed [WE-1:0] SAT_MAX    = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [WE-1:0] SAT_MIN    = {3'b111, {(W-1){1'b0}}};
  localparam logic [SW-1:0]        SHIFT_FILL = SW'(W);
  localparam logic [WE-1:0]        ONE_WE     = {{(WE-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Helper functions
  // --------------------------------------------------------------------------

  // CSD to binary: collect +1 and -1 digit positions separately and subtract.
  // Digit code 10 is a redundant zero and lands in neither set.
  function automatic logic [W-1:0] csd_to_bin(input logic [2*W-1:0] c);
    logic [W-1:0] pos;
    logic [W-1:0] neg;
    pos = '0;
    neg = '0;
    for (int i = 0; i < W; i++) begin
      pos[i] = (c[2*i +: 2] == 2'b01);
      neg[i] = (c[2*i +: 2] == 2'b11);
    end
    return pos - neg;
  endfunction

  // Sign-extend a W-bit word into the guarded internal width.
  function automatic logic signed [WE-1:0] sext(input logic [W-1:0] b);
    return $signed({{2{b[W-1]}}, b});
  endfunction

  // Arithmetic right shift, optionally rounded half-up by adding the last bit
  // shifted out. A clamped full-width shift leaves pure sign fill.
  function automatic logic signed [WE-1:0] shift_term(
    input logic signed [WE-1:0] a,
    input logic [SW-1:0]        amt,
    input logic                 rnd
  );
    logic signed [WE-1:0] q;
    logic [WE-1:0]        mask;
    logic                 rbit;
    q    = a >>> amt;
    mask = ONE_WE << (amt - 1'b1);
    rbit = |(a & mask);
    if (rnd && (amt != '0)) begin
      q = q + $signed({{(WE-1){1'b0}}, rbit});
    end
    return q;
  endfunction

  // Multiply a term by a signed digit in {-1, 0, +1}.
  function automatic logic signed [WE-1:0] apply_digit(
    input logic [1:0]           d,
    input logic signed [WE-1:0] t
  );
    logic signed [WE-1:0] r;
    case (d)
      2'b01:   r = t;
      2'b11:   r = -t;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Reduce the guarded result to W bits: clamp when saturating, else keep low bits.
  function automatic logic [W-1:0] reduce(
    input logic signed [WE-1:0] a,
    input logic                 sat
  );
    logic [W-1:0] r;
    r = a[W-1:0];
    if (sat) begin
      if (a > SAT_MAX) begin
        r = SAT_MAX[W-1:0];
      end else if (a < SAT_MIN) begin
        r = SAT_MIN[W-1:0];
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Format controls
  // --------------------------------------------------------------------------
  logic rnd_en;
  logic sat_en;

  assign rnd_en = format[1];

`ifdef BKM_STEP_SAT_EN
  assign sat_en = format[0];
`else
  // Without saturation hardware every result wraps; format[0] has no effect.
  logic unused_format_sat;
  assign unused_format_sat = format[0];
  assign sat_en            = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Shift amount: n itself, or a full-width shift once n reaches W
  // --------------------------------------------------------------------------
  logic          n_big;
  logic [SW-1:0] shamt;

  assign n_big = (32'(n) >= 32'(W));
  assign shamt = n_big ? SHIFT_FILL : SW'(n);

  // --------------------------------------------------------------------------
  // Operand decode and mode steering
  // --------------------------------------------------------------------------
  logic signed [WE-1:0] x_val, y_val, lx_val, ly_val;
  logic signed [WE-1:0] u_val, v_val, lu_val, lv_val;
  logic signed [WE-1:0] rot_p, rot_q;
  logic signed [WE-1:0] sub_a, sub_a_k, sub_b, sub_b_k;

  // Bring all operands into the guarded signed domain.
  always_comb begin
    x_val  = sext(csd_to_bin(X_n));
    y_val  = sext(csd_to_bin(Y_n));
    lx_val = sext(csd_to_bin(lut_X));
    ly_val = sext(csd_to_bin(lut_Y));
    u_val  = sext(u_n);
    v_val  = sext(v_n);
    lu_val = sext(lut_u);
    lv_val = sext(lut_v);
  end

  // Only one pair rotates per mode, so a single pair of shifters is shared:
  // (X,Y) rotates in E-mode, (u,v) in L-mode; the other pair steps down by the table.
  always_comb begin
    rot_p   = mode ? u_val  : x_val;
    rot_q   = mode ? v_val  : y_val;
    sub_a   = mode ? x_val  : u_val;
    sub_a_k = mode ? lx_val : lu_val;
    sub_b   = mode ? y_val  : v_val;
    sub_b_k = mode ? ly_val : lv_val;
  end

  // --------------------------------------------------------------------------
  // Arithmetic
  // --------------------------------------------------------------------------
  logic signed [WE-1:0] sh_p, sh_q;
  logic signed [WE-1:0] rot_p_nx, rot_q_nx;
  logic signed [WE-1:0] sub_a_nx, sub_b_nx;

  // Rotation pair: p' = p + dx*sh(p) - dy*sh(q); q' = q + dx*sh(q) + dy*sh(p).
  always_comb begin
    sh_p     = shift_term(rot_p, shamt, rnd_en);
    sh_q     = shift_term(rot_q, shamt, rnd_en);
    rot_p_nx = rot_p + apply_digit(d_x_n, sh_p) - apply_digit(d_y_n, sh_q);
    rot_q_nx = rot_q + apply_digit(d_x_n, sh_q) + apply_digit(d_y_n, sh_p);
    sub_a_nx = sub_a - sub_a_k;
    sub_b_nx = sub_b - sub_b_k;
  end

  // --------------------------------------------------------------------------
  // Reduction and routing back to the named results
  // --------------------------------------------------------------------------
  logic [W-1:0] x_res, y_res, u_res, v_res;

  // Route rotation and table results to X/Y/u/v according to mode, then narrow.
  always_comb begin
    if (mode) begin
      x_res = reduce(sub_a_nx, sat_en);
      y_res = reduce(sub_b_nx, sat_en);
      u_res = reduce(rot_p_nx, sat_en);
      v_res = reduce(rot_q_nx, sat_en);
    end else begin
      x_res = reduce(rot_p_nx, sat_en);
      y_res = reduce(rot_q_nx, sat_en);
      u_res = reduce(sub_a_nx, sat_en);
      v_res = reduce(sub_b_nx, sat_en);
    end
  end

  // --------------------------------------------------------------------------
  // Binary to CSD: each bit becomes a +1 digit, except the sign bit which is a
  // -1 digit, so the digit string carries the two's-complement value exactly.
  // --------------------------------------------------------------------------
  logic [2*W-1:0] x_csd, y_csd;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_csd_enc
      if (gi == W - 1) begin : g_sign_digit
        assign x_csd[2*gi +: 2] = {x_res[gi], x_res[gi]};
        assign y_csd[2*gi +: 2] = {y_res[gi], y_res[gi]};
      end else begin : g_mag_digit
        assign x_csd[2*gi +: 2] = {1'b0, x_res[gi]};
        assign y_csd[2*gi +: 2] = {1'b0, y_res[gi]};
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Result registers
  // --------------------------------------------------------------------------
  logic [2*W-1:0] x_np1_d, x_np1_q;
  logic [2*W-1:0] y_np1_d, y_np1_q;
  logic [W-1:0]   u_np1_d, u_np1_q;
  logic [W-1:0]   v_np1_d, v_np1_q;

  // Next state: hold when disabled, clear on srst while enabled, else load the step.
  always_comb begin
    x_np1_d = x_np1_q;
    y_np1_d = y_np1_q;
    u_np1_d = u_np1_q;
    v_np1_d = v_np1_q;
    if (enable) begin
      if (srst) begin
        x_np1_d = '0;
        y_np1_d = '0;
        u_np1_d = '0;
        v_np1_d = '0;
      end else begin
        x_np1_d = x_csd;
        y_np1_d = y_csd;
        u_np1_d = u_res;
        v_np1_d = v_res;
      end
    end
  end

  // arst clears unconditionally and overrides enable and srst.
  always_ff @(posedge clk) begin
    if (arst) begin
      x_np1_q <= '0;
      y_np1_q <= '0;
      u_np1_q <= '0;
      v_np1_q <= '0;
    end else begin
      x_np1_q <= x_np1_d;
      y_np1_q <= y_np1_d;
      u_np1_q <= u_np1_d;
      v_np1_q <= v_np1_d;
    end
  end

  assign X_np1 = x_np1_q;
  assign Y_np1 = y_np1_q;
  assign u_np1 = u_np1_q;
  assign v_np1 = v_np1_q;

endmodule
`default_nettype wire

// File: tb/tb_bkm_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bkm_step                                                  |
// | Description : Self-checking bench for bkm_step (W=8) against an integer    |
// |               reference model of the step equations.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bkm_step;

  localparam int W     = 8;
  localparam int LOG2W = 3;
  localparam int LOG2N = 3;

  logic             clk;
  logic             arst, srst, enable, mode;
  logic [1:0]       format;
  logic [LOG2N-1:0] n;
  logic [1:0]       d_x_n, d_y_n;
  logic [2*W-1:0]   X_n, Y_n, lut_X, lut_Y;
  logic [W-1:0]     u_n, v_n, lut_u, lut_v;
  logic [2*W-1:0]   X_np1, Y_np1;
  logic [W-1:0]     u_np1, v_np1;

  int    n_pass  = 0;
  int    n_total = 0;
  int    exp_q[4];
  int    obs[4];
  string names[4] = '{"X", "Y", "u", "v"};

  bkm_step #(.W(W), .LOG2W(LOG2W), .LOG2N(LOG2N)) dut (
    .clk(clk), .arst(arst), .srst(srst), .enable(enable), .mode(mode),
    .format(format), .n(n), .d_x_n(d_x_n), .d_y_n(d_y_n),
    .X_n(X_n), .Y_n(Y_n), .lut_X(lut_X), .lut_Y(lut_Y),
    .u_n(u_n), .v_n(v_n), .lut_u(lut_u), .lut_v(lut_v),
    .X_np1(X_np1), .Y_np1(Y_np1), .u_np1(u_np1), .v_np1(v_np1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- reference model (plain integer arithmetic) --------------
  function automatic int wrapw(longint v);
    longint m;
    longint md;
    md = longint'(1) << W;
    m  = v % md;
    if (m < 0) m += md;
    if (m >= (md >> 1)) m -= md;
    return int'(m);
  endfunction

  function automatic int csd_val(logic [2*W-1:0] c);
    longint s;
    logic [1:0] d;
    s = 0;
    for (int i = 0; i < W; i++) begin
      d = c[2*i +: 2];
      if (d == 2'b01) s += longint'(1) << i;
      else if (d == 2'b11) s -= longint'(1) << i;
    end
    return wrapw(s);
  endfunction

  function automatic logic [2*W-1:0] to_csd(int v);
    logic [2*W-1:0] c;
    logic [W-1:0]   b;
    b = W'(v);
    c = '0;
    for (int i = 0; i < W; i++) c[2*i +: 2] = b[i] ? 2'b01 : 2'b00;
    return c;
  endfunction

  function automatic int digit(logic [1:0] d);
    if (d == 2'b01) return 1;
    if (d == 2'b11) return -1;
    return 0;
  endfunction

  function automatic longint floor_div(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Scaled term: a / 2^n rounded down, or rounded half-up when requested.
  function automatic longint sh(longint a, int nn, bit rnd);
    longint p;
    p = longint'(1) << nn;
    if (rnd && nn >= 1) return floor_div(a + (p / 2), p);
    return floor_div(a, p);
  endfunction

  function automatic int reduce_m(longint v, bit sat);
    longint hi;
    hi = (longint'(1) << (W - 1)) - 1;
    if (sat) begin
      if (v > hi) return int'(hi);
      if (v < -hi - 1) return int'(-hi - 1);
      return int'(v);
    end
    return wrapw(v);
  endfunction

  // Advance the expected register state for the coming clock edge.
  task automatic model_edge();
    longint xv, yv, uv, vv, r[4];
    int dx, dy, nn;
    bit rnd, sat;
    if (arst) begin
      for (int k = 0; k < 4; k++) exp_q[k] = 0;
      return;
    end
    if (!enable) return;
    if (srst) begin
      for (int k = 0; k < 4; k++) exp_q[k] = 0;
      return;
    end
    dx = digit(d_x_n);
    dy = digit(d_y_n);
    nn = int'(n);
    rnd = format[1];
`ifdef BKM_STEP_SAT_EN
    sat = format[0];
`else
    sat = 1'b0;
`endif
    xv = csd_val(X_n);
    yv = csd_val(Y_n);
    uv = int'($signed(u_n));
    vv = int'($signed(v_n));
    if (!mode) begin
      r[0] = xv + dx * sh(xv, nn, rnd) - dy * sh(yv, nn, rnd);
      r[1] = yv + dx * sh(yv, nn, rnd) + dy * sh(xv, nn, rnd);
      r[2] = uv - int'($signed(lut_u));
      r[3] = vv - int'($signed(lut_v));
    end else begin
      r[0] = xv - csd_val(lut_X);
      r[1] = yv - csd_val(lut_Y);
      r[2] = uv + dx * sh(uv, nn, rnd) - dy * sh(vv, nn, rnd);
      r[3] = vv + dx * sh(vv, nn, rnd) + dy * sh(uv, nn, rnd);
    end
    for (int k = 0; k < 4; k++) exp_q[k] = reduce_m(r[k], sat);
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_obs();
    obs[0] = csd_val(X_np1);
    obs[1] = csd_val(Y_np1);
    obs[2] = int'($signed(u_np1));
    obs[3] = int'($signed(v_np1));
  endtask

  task automatic clear_ops();
    arst = 0; srst = 0; enable = 1; mode = 0; format = 2'b00; n = '0;
    d_x_n = 2'b00; d_y_n = 2'b00;
    X_n = '0; Y_n = '0; lut_X = '0; lut_Y = '0;
    u_n = '0; v_n = '0; lut_u = '0; lut_v = '0;
  endtask

  task automatic randomize_ops();
    mode   = 1'($urandom);
    format = 2'($urandom);
    n      = LOG2N'($urandom);
    d_x_n  = 2'($urandom);
    d_y_n  = 2'($urandom);
    X_n    = (2*W)'($urandom);
    Y_n    = (2*W)'($urandom);
    lut_X  = (2*W)'($urandom);
    lut_Y  = (2*W)'($urandom);
    u_n    = W'($urandom);
    v_n    = W'($urandom);
    lut_u  = W'($urandom);
    lut_v  = W'($urandom);
  endtask

  // ---------------- tests ----------------------------------------------------
  task automatic test_reset();
    clear_ops();
    randomize_ops();
    arst = 1; enable = 0;
    step();
    sample_obs();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (obs[k] !== 0) $display("FAIL reset %s: got %0d required 0", names[k], obs[k]);
      else n_pass++;
    end
    arst = 0;
  endtask

  task automatic test_scenarios();
    int exp3;
    // Scenario 1
    clear_ops();
    n = 1; d_x_n = 2'b01; X_n = to_csd(64); u_n = 8'd10; lut_u = 8'd3;
    step(); sample_obs();
    n_total++; if (obs[0] !== 96) $display("FAIL scen1 X: got %0d required 96", obs[0]); else n_pass++;
    n_total++; if (obs[1] !== 0)  $display("FAIL scen1 Y: got %0d required 0", obs[1]);  else n_pass++;
    n_total++; if (obs[2] !== 7)  $display("FAIL scen1 u: got %0d required 7", obs[2]);  else n_pass++;
    // Scenario 2
    clear_ops();
    n = 2; d_y_n = 2'b01; X_n = to_csd(64); Y_n = to_csd(32);
    step(); sample_obs();
    n_total++; if (obs[0] !== 56) $display("FAIL scen2 X: got %0d required 56", obs[0]); else n_pass++;
    n_total++; if (obs[1] !== 48) $display("FAIL scen2 Y: got %0d required 48", obs[1]); else n_pass++;
    // Scenario 3: saturating format (only effective with saturation compiled in)
`ifdef BKM_STEP_SAT_EN
    exp3 = 127;
`else
    exp3 = -76;
`endif
    clear_ops();
    n = 1; d_x_n = 2'b01; X_n = to_csd(120); format = 2'b01;
    step(); sample_obs();
    n_total++; if (obs[0] !== exp3) $display("FAIL scen3 sat X: got %0d required %0d", obs[0], exp3); else n_pass++;
    format = 2'b00;
    step(); sample_obs();
    n_total++; if (obs[0] !== -76) $display("FAIL scen3 wrap X: got %0d required -76", obs[0]); else n_pass++;
    // Scenario 4: L-mode
    clear_ops();
    mode = 1; n = 1; d_x_n = 2'b11; X_n = to_csd(50); lut_X = to_csd(20); u_n = 8'hC0;
    step(); sample_obs();
    n_total++; if (obs[0] !== 30)  $display("FAIL scen4 X: got %0d required 30", obs[0]);  else n_pass++;
    n_total++; if (obs[2] !== -32) $display("FAIL scen4 u: got %0d required -32", obs[2]); else n_pass++;
    // Scenario 5: round vs truncate
    clear_ops();
    n = 1; d_x_n = 2'b01; X_n = to_csd(3); format = 2'b10;
    step(); sample_obs();
    n_total++; if (obs[0] !== 5) $display("FAIL scen5 round X: got %0d required 5", obs[0]); else n_pass++;
    format = 2'b00;
    step(); sample_obs();
    n_total++; if (obs[0] !== 4) $display("FAIL scen5 trunc X: got %0d required 4", obs[0]); else n_pass++;
  endtask

  task automatic test_enable_hold();
    clear_ops();
    randomize_ops();
    step();
    for (int c = 0; c < 6; c++) begin
      randomize_ops();
      enable = 0;
      srst = (c >= 3);
      step(); sample_obs();
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if (obs[k] !== exp_q[k]) $display("FAIL hold[%0d] %s: got %0d required %0d", c, names[k], obs[k], exp_q[k]);
        else n_pass++;
      end
    end
    srst = 0; enable = 1;
  endtask

  task automatic test_srst();
    clear_ops();
    randomize_ops();
    step();
    randomize_ops();
    srst = 1;
    step(); sample_obs();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (obs[k] !== 0) $display("FAIL srst %s: got %0d required 0", names[k], obs[k]);
      else n_pass++;
    end
    srst = 0;
  endtask

  task automatic test_boundary();
    clear_ops();
    for (int nn = 0; nn < 8; nn++) begin
      for (int f = 0; f < 4; f++) begin
        mode   = 1'(f ^ nn);
        n      = LOG2N'(nn);
        format = 2'(f);
        d_x_n  = (nn % 2 == 0) ? 2'b01 : 2'b11;
        d_y_n  = (f % 2 == 0) ? 2'b11 : 2'b01;
        X_n    = to_csd((nn % 2 == 0) ? 127 : -128);
        Y_n    = to_csd(-128);
        u_n    = (f % 2 == 0) ? 8'h7F : 8'h81;
        v_n    = 8'h80;
        lut_X  = to_csd(-128);
        lut_Y  = to_csd(127);
        lut_u  = 8'h80;
        lut_v  = 8'h7F;
        step(); sample_obs();
        for (int k = 0; k < 4; k++) begin
          n_total++;
          if (obs[k] !== exp_q[k]) $display("FAIL boundary n=%0d f=%0d %s: got %0d required %0d", nn, f, names[k], obs[k], exp_q[k]);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_ops();
    for (int it = 0; it < 300; it++) begin
      randomize_ops();
      enable = ($urandom_range(0, 99) < 85);
      arst   = ($urandom_range(0, 99) < 4);
      srst   = ($urandom_range(0, 99) < 5);
      step(); sample_obs();
      for (int k = 0; k < 4; k++) begin
        n_total++;
        if (obs[k] !== exp_q[k]) $display("FAIL random[%0d] %s: got %0d required %0d", it, names[k], obs[k], exp_q[k]);
        else n_pass++;
      end
    end
    arst = 0; srst = 0; enable = 1;
  endtask

  initial begin
    clear_ops();
    test_reset();
    test_scenarios();
    test_enable_hold();
    test_srst();
    test_reset();
    test_boundary();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
